// File: rtl/uart_pkg.sv
// Shared UART types and constants.
// Holds the default byte width and the TX feeder state encoding.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    FD_IDLE,
    FD_LAUNCH,
    FD_DRAIN
  } feeder_state_e;

endpackage

// File: rtl/uart_tx_byte_feeder_if.sv
// Feeder-to-PHY launch handshake.
// master: drives phy_start/phy_data, sees phy_tx_busy; slave: the PHY side.
interface uart_tx_byte_feeder_if #(
  parameter int DATA_W = 8
);

  logic              phy_start;
  logic [DATA_W-1:0] phy_data;
  logic              phy_tx_busy;

  modport master (
    output phy_start,
    output phy_data,
    input  phy_tx_busy
  );

  modport slave (
    input  phy_start,
    input  phy_data,
    output phy_tx_busy
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous show-ahead FIFO with registered level/full/empty.
// Ports: clk, rst_n, push_i/din_i, pop_i, head_o, full_o, empty_o, level_o.
module uart_sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          din_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              do_push, do_pop;

  // Both decisions use the pre-cycle flags.
  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    full_d  = (level_d == LW'(DEPTH));
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

  assign head_o  = mem_q[rptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;

endmodule

// File: rtl/uart_tx_byte_feeder.sv
// Buffers bytes and launches them one at a time into the UART TX PHY.
// Ports: system_clock, rst_n, host write side, phy (master), FIFO status.
module uart_tx_byte_feeder #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = uart_pkg::DATA_W
) (
  input  logic                       system_clock,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       tx_en,
  input  logic                       clr_overflow,
  uart_tx_byte_feeder_if.master      phy,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow
);

  import uart_pkg::*;

  feeder_state_e     state_q, state_d;
  logic              start_q, start_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ovf_q, ovf_d;
  logic              pop;
  logic [DATA_W-1:0] head;
  logic              fifo_full;
  logic              fifo_empty;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (system_clock),
    .rst_n   (rst_n),
    .push_i  (wr_en),
    .din_i   (wr_data),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  // phy_start is a level held until busy is seen, since the PHY
  // only samples it on its baud tick; data is frozen meanwhile.
  always_comb begin
    state_d = state_q;
    start_d = start_q;
    data_d  = data_q;
    pop     = 1'b0;
    case (state_q)
      FD_IDLE: begin
        if (tx_en && !fifo_empty && !phy.phy_tx_busy) begin
          pop     = 1'b1;
          data_d  = head;
          start_d = 1'b1;
          state_d = FD_LAUNCH;
        end
      end
      FD_LAUNCH: begin
        if (phy.phy_tx_busy) begin
          start_d = 1'b0;
          state_d = FD_DRAIN;
        end
      end
      FD_DRAIN: begin
        start_d = 1'b0;
        if (!phy.phy_tx_busy) state_d = FD_IDLE;
      end
      default: begin
        start_d = 1'b0;
        state_d = FD_IDLE;
      end
    endcase
  end

  // A dropped write beats a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_en && fifo_full) ovf_d = 1'b1;
    else if (clr_overflow)  ovf_d = 1'b0;
  end

  always_ff @(posedge system_clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FD_IDLE;
      start_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign phy.phy_start = start_q;
  assign phy.phy_data  = data_q;
  assign full          = fifo_full;
  assign empty         = fifo_empty;
  assign overflow      = ovf_q;

endmodule
